parity_stream_checker: RTL

//   Parametrised streaming odd/even parity checker.
//   - Accepts framed words, each with a transmitted parity bit, over a valid/ready handshake.
//   - Flags each word's parity error and reports a per-frame error summary and frame length.
//   - Sits between a link receiver and downstream consumers.
//   - Generalises the 4-bit combinational odd-parity check to any width, runtime mode and framing.

---
 rtl/parity_pkg.sv | 9 +
 rtl/parity_word_check.sv | 27 ++
 rtl/parity_stream_checker.sv | 123 ++++++++++++
 3 files changed

// File: rtl/parity_pkg.sv
// Shared types and constants for the parity checker family.
package parity_pkg;

   typedef enum logic {IDLE, IN_FRAME} pchk_state_t;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_word_check.sv
// Combinational parity check of one word plus its transmitted parity bit.
module parity_word_check
   import parity_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  logic [DATA_W-1:0] data,
   input  logic              par,
   input  logic              mode,
   output logic              err
);

   logic p;

   assign p = ^data ^ par;

   // Odd mode wants an odd count of ones over data and parity, i.e. p = 1.
   always_comb begin
      err = p;
      case (mode)
         PAR_ODD:  err = ~p;
         PAR_EVEN: err = p;
         default:  err = p;
      endcase
   end

endmodule

// File: rtl/parity_stream_checker.sv
// Streaming framed parity checker with a single registered result stage.
// Optional saturating word-error counter built when PARITY_ERR_CNT_EN is defined.
module parity_stream_checker
   import parity_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned LEN_W  = 8
`ifdef PARITY_ERR_CNT_EN
   ,
   parameter int unsigned CNT_W  = 16
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              odd_mode,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_par,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_word_err,
   output logic              out_frame_done,
   output logic              out_frame_err,
   output logic [LEN_W-1:0]  out_frame_len
`ifdef PARITY_ERR_CNT_EN
   ,
   input  logic              clr_cnt,
   output logic [CNT_W-1:0]  err_cnt
`endif
);

   localparam logic [LEN_W-1:0] LEN_ONE = 1;

   pchk_state_t      state_q;
   logic             mode_q;
   logic             sticky_q;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] len_inc;
   logic             accept;
   logic             word_mode;
   logic             word_err;

   assign in_ready  = !out_valid || out_ready;
   assign accept    = in_valid && in_ready;
   // The first word of a frame sees odd_mode directly; later words use the latched mode.
   assign word_mode = (state_q == IDLE) ? odd_mode : mode_q;
   assign len_inc   = (len_q == '1) ? len_q : len_q + LEN_ONE;

   parity_word_check #(
      .DATA_W(DATA_W)
   ) u_word_check (
      .data(in_data),
      .par (in_par),
      .mode(word_mode),
      .err (word_err)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         mode_q         <= PAR_EVEN;
         sticky_q       <= 1'b0;
         len_q          <= '0;
         out_valid      <= 1'b0;
         out_word_err   <= 1'b0;
         out_frame_done <= 1'b0;
         out_frame_err  <= 1'b0;
         out_frame_len  <= '0;
      end else if (accept) begin
         out_valid      <= 1'b1;
         out_word_err   <= word_err;
         out_frame_done <= in_last;
         out_frame_err  <= 1'b0;
         out_frame_len  <= '0;
         case (state_q)
            IDLE: begin
               if (in_last) begin
                  out_frame_err <= word_err;
                  out_frame_len <= LEN_ONE;
               end else begin
                  state_q  <= IN_FRAME;
                  mode_q   <= odd_mode;
                  sticky_q <= word_err;
                  len_q    <= LEN_ONE;
               end
            end
            IN_FRAME: begin
               if (in_last) begin
                  out_frame_err <= sticky_q | word_err;
                  out_frame_len <= len_inc;
                  state_q       <= IDLE;
                  sticky_q      <= 1'b0;
                  len_q         <= '0;
               end else begin
                  sticky_q <= sticky_q | word_err;
                  len_q    <= len_inc;
               end
            end
            default: state_q <= IDLE;
         endcase
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef PARITY_ERR_CNT_EN
   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   // Clear takes priority over a same-cycle increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt <= '0;
      end else if (clr_cnt) begin
         err_cnt <= '0;
      end else if (accept && word_err && (err_cnt != '1)) begin
         err_cnt <= err_cnt + CNT_ONE;
      end
   end
`endif

endmodule
